// File: rtl/alu_core.sv
// alu_core: registered ALU, one-cycle latency; in: clk rst in_valid op a b, out: out_valid result zero negative carry overflow
module alu_core #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);
  localparam int M = WIDTH - 1;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, overflow_q, overflow_d;
  logic [WIDTH:0]   sum, diff, inc, dec;
  logic [SHW-1:0]   sh;
  assign sh   = b[SHW-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign inc  = {1'b0, a} + 1'b1;
  assign dec  = {1'b0, a} - 1'b1;
  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op)
      4'd0: begin
        result_d   = sum[M:0];
        carry_d    = sum[WIDTH];
        overflow_d = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      4'd1: begin
        result_d   = diff[M:0];
        carry_d    = diff[WIDTH];
        overflow_d = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      4'd2:  result_d = a & b;
      4'd3:  result_d = a | b;
      4'd4:  result_d = a ^ b;
      4'd5:  result_d = ~(a | b);
      4'd6:  result_d = a << sh;
      4'd7:  result_d = a >> sh;
      4'd8:  result_d = WIDTH'($signed(a) >>> sh);
      4'd9:  result_d = WIDTH'($signed(a) < $signed(b));
      4'd10: result_d = WIDTH'(a < b);
      4'd11: result_d = a;
      4'd12: result_d = b;
      4'd13: begin
        result_d   = inc[M:0];
        carry_d    = inc[WIDTH];
        overflow_d = !a[M] && inc[M];
      end
      4'd14: begin
        result_d   = dec[M:0];
        carry_d    = dec[WIDTH];
        overflow_d = a[M] && !dec[M];
      end
      default: result_d = ~a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = result_q == '0;
  assign negative  = result_q[M];
  assign carry     = carry_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: table-driven self-checking bench for alu_core
module tb_alu_core;
  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid, zero, negative, carry, overflow;
  logic [31:0] result;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        c, v, z, n;
  } vec_t;
  vec_t vecs[18];
  alu_core #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic ov, input logic [31:0] r,
                         input logic c, input logic v, input logic z, input logic n);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".result"}, result, r);
    chk({tag, ".carry"}, 32'(carry), 32'(c));
    chk({tag, ".overflow"}, 32'(overflow), 32'(v));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".negative"}, 32'(negative), 32'(n));
  endtask
  task automatic drive(input logic vld, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = vld;
    op = o;
    a = x;
    b = y;
  endtask
  initial begin
    vecs = '{
      '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0},
      '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1},
      '{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1},
      '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0},
      '{4'd6,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'd8,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b1},
      '{4'd7,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1},
      '{4'd11, 32'h12345678, 32'h00000009, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'd12, 32'h12345678, 32'h00000009, 32'h00000009, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'd13, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1},
      '{4'd13, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0},
      '{4'd14, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1},
      '{4'd14, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0},
      '{4'd15, 32'h0F0F0F0F, 32'h00000000, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0},
      '{4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0}
    };
    rst = 1'b1;
    drive(1'b1, 4'd0, 32'h1, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    rst = 1'b0;
    step;
    chk_all("first", 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      step;
      chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
    end
    drive(1'b1, 4'd2, 32'hF0F0F0F0, 32'hFF00FF00);
    step;
    chk_all("and", 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'd3, 32'hF0F0F0F0, 32'hFF00FF00);
    step;
    chk_all("or", 1'b1, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'd4, 32'hF0F0F0F0, 32'hFF00FF00);
    step;
    chk_all("xor", 1'b1, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'hFFFFFFFF, 32'h00000001);
    step;
    chk_all("hold1", 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    chk_all("hold2", 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'h80000000, 32'h80000000);
    step;
    chk_all("addov", 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 4'd1, 32'h5, 32'h3);
    step;
    chk_all("holdflags", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'd1, 32'h3, 32'h5);
    step;
    chk_all("sub2", 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step;
    chk_all("midrst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b1, 4'd12, 32'h0, 32'h80000001);
    step;
    chk_all("afterrst", 1'b1, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    step;
    chk("idle.out_valid", 32'(out_valid), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
